if_id_queue: RTL and testbench

IF_ID_QUEUE -- requirements
Module: if_id_queue

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/if_id_queue_mem.sv | 26 ++
 rtl/if_id_queue.sv | 120 ++++++++++++
 tb/tb_if_id_queue.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: exception codes and the fetch-entry record
// carried from IF to ID.
package cpu_pkg;

    localparam int EXCODE_W = 5;

    localparam logic [EXCODE_W-1:0] EXC_INT  = 5'h00;
    localparam logic [EXCODE_W-1:0] EXC_ADEL = 5'h04;
    localparam logic [EXCODE_W-1:0] EXC_ADES = 5'h05;
    localparam logic [EXCODE_W-1:0] EXC_SYS  = 5'h08;
    localparam logic [EXCODE_W-1:0] EXC_BP   = 5'h09;
    localparam logic [EXCODE_W-1:0] EXC_RI   = 5'h0a;
    localparam logic [EXCODE_W-1:0] EXC_OV   = 5'h0c;

    localparam int FE_PC_W   = 32;
    localparam int FE_INST_W = 32;

    // Field order here is also the bit order used when an entry is flattened.
    typedef struct packed {
        logic [FE_PC_W-1:0]   pc;
        logic [FE_INST_W-1:0] inst;
        logic                 ex;
        logic [EXCODE_W-1:0]  excode;
        logic [FE_PC_W-1:0]   badvaddr;
    } fetch_entry_t;

endpackage

// File: rtl/if_id_queue_mem.sv
// Entry storage for the IF/ID queue: one synchronous write port, one
// asynchronous read port; no reset, contents are qualified by the pointers.
module if_id_queue_mem #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 102,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/if_id_queue.sv
// Fetch-to-decode entry queue: registered head, one cycle minimum latency,
// in_ready depends only on occupancy; flush/reset empty it in one cycle.
module if_id_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int PC_W   = 32,
    parameter int INST_W = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [PC_W-1:0]           in_pc,
    input  logic [INST_W-1:0]         in_inst,
    input  logic                      in_ex,
    input  logic [EXCODE_W-1:0]       in_excode,
    input  logic [PC_W-1:0]           in_badvaddr,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [PC_W-1:0]           out_pc,
    output logic [INST_W-1:0]         out_inst,
    output logic                      out_ex,
    output logic [EXCODE_W-1:0]       out_excode,
    output logic [PC_W-1:0]           out_badvaddr,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = PC_W + INST_W + 1 + EXCODE_W + PC_W;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic          push;
    logic          pop;
    logic [EW-1:0] wr_dat;
    logic [EW-1:0] rd_dat;

    logic [PC_W-1:0]     head_pc;
    logic [INST_W-1:0]   head_inst;
    logic                head_ex;
    logic [EXCODE_W-1:0] head_excode;
    logic [PC_W-1:0]     head_badvaddr;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign in_ready = !full;
    assign count    = count_q;

    // Refusal when full is independent of out_ready, keeping in_ready registered-only.
    assign push = in_valid && !full;
    assign pop  = !empty && out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign wr_dat = {in_pc, in_inst, in_ex, in_excode, in_badvaddr};

    if_id_queue_mem #(
        .DEPTH (DEPTH),
        .WIDTH (EW),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push && !flush && !reset),
        .waddr (wr_ptr_q),
        .wdata (wr_dat),
        .raddr (rd_ptr_q),
        .rdata (rd_dat)
    );

    assign {head_pc, head_inst, head_ex, head_excode, head_badvaddr} = rd_dat;

    // Empty queue presents an all-zero bubble so decode sees a NOP.
    assign out_valid    = !empty;
    assign out_pc       = empty ? '0 : head_pc;
    assign out_inst     = empty ? '0 : head_inst;
    assign out_ex       = empty ? 1'b0 : head_ex;
    assign out_excode   = empty ? '0 : head_excode;
    assign out_badvaddr = empty ? '0 : head_badvaddr;

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: DEPTH=2/4/8 instances share stimulus, each checked
// against its own queue model; DEPTH=4 also checked against fixed vectors.
module tb_if_id_queue;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready, in_ex;
    logic [31:0] in_pc, in_inst, in_badvaddr;
    logic [4:0]  in_excode;

    logic        in_ready_w [3];
    logic        out_valid_w[3];
    logic        out_ex_w   [3];
    logic        full_w     [3];
    logic        empty_w    [3];
    logic [31:0] out_pc_w   [3];
    logic [31:0] out_inst_w [3];
    logic [31:0] out_bad_w  [3];
    logic [4:0]  out_exc_w  [3];
    logic [1:0]  count2;
    logic [2:0]  count4;
    logic [3:0]  count8;

    int passed = 0;
    int total  = 0;
    fetch_entry_t mq[3][$];

    always #5 clk = ~clk;

    if_id_queue #(.DEPTH(2)) u_d2 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_w[0]),
        .in_pc(in_pc), .in_inst(in_inst), .in_ex(in_ex),
        .in_excode(in_excode), .in_badvaddr(in_badvaddr),
        .out_valid(out_valid_w[0]), .out_ready(out_ready),
        .out_pc(out_pc_w[0]), .out_inst(out_inst_w[0]), .out_ex(out_ex_w[0]),
        .out_excode(out_exc_w[0]), .out_badvaddr(out_bad_w[0]),
        .count(count2), .full(full_w[0]), .empty(empty_w[0])
    );

    if_id_queue #(.DEPTH(4)) u_d4 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_w[1]),
        .in_pc(in_pc), .in_inst(in_inst), .in_ex(in_ex),
        .in_excode(in_excode), .in_badvaddr(in_badvaddr),
        .out_valid(out_valid_w[1]), .out_ready(out_ready),
        .out_pc(out_pc_w[1]), .out_inst(out_inst_w[1]), .out_ex(out_ex_w[1]),
        .out_excode(out_exc_w[1]), .out_badvaddr(out_bad_w[1]),
        .count(count4), .full(full_w[1]), .empty(empty_w[1])
    );

    if_id_queue #(.DEPTH(8)) u_d8 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_w[2]),
        .in_pc(in_pc), .in_inst(in_inst), .in_ex(in_ex),
        .in_excode(in_excode), .in_badvaddr(in_badvaddr),
        .out_valid(out_valid_w[2]), .out_ready(out_ready),
        .out_pc(out_pc_w[2]), .out_inst(out_inst_w[2]), .out_ex(out_ex_w[2]),
        .out_excode(out_exc_w[2]), .out_badvaddr(out_bad_w[2]),
        .count(count8), .full(full_w[2]), .empty(empty_w[2])
    );

    function automatic int depth_of(int i);
        return (i == 0) ? 2 : (i == 1) ? 4 : 8;
    endfunction

    function automatic int dut_count(int i);
        return (i == 0) ? int'(count2) : (i == 1) ? int'(count4) : int'(count8);
    endfunction

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    task automatic model_check();
        for (int i = 0; i < 3; i++) begin
            int           sz;
            fetch_entry_t head;
            fetch_entry_t got;
            string        tag;
            sz   = mq[i].size();
            head = (sz > 0) ? mq[i][0] : '0;
            got  = {out_pc_w[i], out_inst_w[i], out_ex_w[i], out_exc_w[i], out_bad_w[i]};
            tag  = $sformatf("d%0d", depth_of(i));
            chk({tag, "_count"},     128'(dut_count(i)), 128'(sz));
            chk({tag, "_out_valid"}, 128'(out_valid_w[i]), 128'(sz > 0));
            chk({tag, "_empty"},     128'(empty_w[i]), 128'(sz == 0));
            chk({tag, "_full"},      128'(full_w[i]), 128'(sz == depth_of(i)));
            chk({tag, "_in_ready"},  128'(in_ready_w[i]), 128'(sz != depth_of(i)));
            chk({tag, "_head"},      128'(got), 128'(head));
        end
    endtask

    // Inputs are already driven; advance one edge, update models, then compare.
    task automatic tick();
        bit           pu[3];
        bit           po[3];
        fetch_entry_t ent;
        for (int i = 0; i < 3; i++) begin
            pu[i] = in_valid && (mq[i].size() < depth_of(i));
            po[i] = out_ready && (mq[i].size() > 0);
        end
        ent = {in_pc, in_inst, in_ex, in_excode, in_badvaddr};
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (reset || flush) begin
                mq[i].delete();
            end else begin
                if (po[i]) void'(mq[i].pop_front());
                if (pu[i]) mq[i].push_back(ent);
            end
        end
        #1;
        model_check();
    endtask

    task automatic drive(logic rst, logic fl, logic iv, logic ordy,
                         logic [31:0] pc, logic [31:0] inst,
                         logic ex, logic [4:0] exc, logic [31:0] bad);
        reset = rst; flush = fl; in_valid = iv; out_ready = ordy;
        in_pc = pc; in_inst = inst; in_ex = ex; in_excode = exc; in_badvaddr = bad;
    endtask

    typedef struct {
        logic        rst, fl, iv, ordy;
        logic [31:0] pc, inst;
        int          e_cnt;
        logic        e_ov;
        logic [31:0] e_pc, e_inst;
        logic        e_full;
    } vec_t;

    function automatic vec_t mkv(logic rst, logic fl, logic iv, logic ordy,
                                 logic [31:0] pc, logic [31:0] inst, int e_cnt,
                                 logic e_ov, logic [31:0] e_pc, logic [31:0] e_inst,
                                 logic e_full);
        vec_t v;
        v.rst = rst; v.fl = fl; v.iv = iv; v.ordy = ordy; v.pc = pc; v.inst = inst;
        v.e_cnt = e_cnt; v.e_ov = e_ov; v.e_pc = e_pc; v.e_inst = e_inst; v.e_full = e_full;
        return v;
    endfunction

    initial begin
        vec_t tbl[$];
        int   rdy_pct;

        drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);

        // reset
        tbl.push_back(mkv(1,0,0,0, 32'h0,        32'h0,        0,0,32'h0,        32'h0,        0));
        // pass-through, one entry in flight at a time
        tbl.push_back(mkv(0,0,1,1, 32'h00400000, 32'h24010001, 1,1,32'h00400000, 32'h24010001, 0));
        tbl.push_back(mkv(0,0,1,1, 32'h00400004, 32'h24010002, 1,1,32'h00400004, 32'h24010002, 0));
        tbl.push_back(mkv(0,0,1,1, 32'h00400008, 32'h24010003, 1,1,32'h00400008, 32'h24010003, 0));
        tbl.push_back(mkv(0,0,1,1, 32'h0040000C, 32'h24010004, 1,1,32'h0040000C, 32'h24010004, 0));
        tbl.push_back(mkv(0,0,0,1, 32'h0,        32'h0,        0,0,32'h0,        32'h0,        0));
        // stall decode and overfill
        tbl.push_back(mkv(0,0,1,0, 32'h00400000, 32'h24010011, 1,1,32'h00400000, 32'h24010011, 0));
        tbl.push_back(mkv(0,0,1,0, 32'h00400004, 32'h24010012, 2,1,32'h00400000, 32'h24010011, 0));
        tbl.push_back(mkv(0,0,1,0, 32'h00400008, 32'h24010013, 3,1,32'h00400000, 32'h24010011, 0));
        tbl.push_back(mkv(0,0,1,0, 32'h0040000C, 32'h24010014, 4,1,32'h00400000, 32'h24010011, 1));
        tbl.push_back(mkv(0,0,1,0, 32'h00400010, 32'h24010015, 4,1,32'h00400000, 32'h24010011, 1));
        // full with push and pop together: pop only
        tbl.push_back(mkv(0,0,1,1, 32'h00400014, 32'h24010016, 3,1,32'h00400004, 32'h24010012, 0));
        tbl.push_back(mkv(0,0,0,1, 32'h0,        32'h0,        2,1,32'h00400008, 32'h24010013, 0));
        tbl.push_back(mkv(0,0,1,0, 32'h00400020, 32'h24010020, 3,1,32'h00400008, 32'h24010013, 0));
        // flush beats a coincident push/pop; dropped entry never shows up
        tbl.push_back(mkv(0,1,1,1, 32'h00400024, 32'h24010024, 0,0,32'h0,        32'h0,        0));
        tbl.push_back(mkv(0,0,0,1, 32'h0,        32'h0,        0,0,32'h0,        32'h0,        0));
        // refill and drain in order after flush
        tbl.push_back(mkv(0,0,1,0, 32'h00400030, 32'h24010030, 1,1,32'h00400030, 32'h24010030, 0));
        tbl.push_back(mkv(0,0,1,0, 32'h00400034, 32'h24010034, 2,1,32'h00400030, 32'h24010030, 0));
        tbl.push_back(mkv(0,0,0,1, 32'h0,        32'h0,        1,1,32'h00400034, 32'h24010034, 0));
        tbl.push_back(mkv(0,0,0,1, 32'h0,        32'h0,        0,0,32'h0,        32'h0,        0));

        for (int r = 0; r < tbl.size(); r++) begin
            drive(tbl[r].rst, tbl[r].fl, tbl[r].iv, tbl[r].ordy,
                  tbl[r].pc, tbl[r].inst, 1'b0, 5'h0, 32'h0);
            tick();
            chk($sformatf("vec%0d_count", r),     128'(count4),          128'(tbl[r].e_cnt));
            chk($sformatf("vec%0d_out_valid", r), 128'(out_valid_w[1]),  128'(tbl[r].e_ov));
            chk($sformatf("vec%0d_out_pc", r),    128'(out_pc_w[1]),     128'(tbl[r].e_pc));
            chk($sformatf("vec%0d_out_inst", r),  128'(out_inst_w[1]),   128'(tbl[r].e_inst));
            chk($sformatf("vec%0d_full", r),      128'(full_w[1]),       128'(tbl[r].e_full));
            chk($sformatf("vec%0d_in_ready", r),  128'(in_ready_w[1]),   128'(!tbl[r].e_full));
        end

        // exception fields travel with their entry; neighbours stay clean
        drive(0, 0, 1, 0, 32'h00400040, 32'h24010040, 1'b0, 5'h00, 32'h0);
        tick();
        drive(0, 0, 1, 0, 32'h00400044, 32'h24010044, 1'b1, EXC_ADEL, 32'h00400001);
        tick();
        drive(0, 0, 1, 0, 32'h00400048, 32'h24010048, 1'b0, 5'h00, 32'h0);
        tick();
        chk("exc_first_ex", 128'(out_ex_w[1]), 128'(0));
        drive(0, 0, 0, 1, 32'h0, 32'h0, 1'b0, 5'h00, 32'h0);
        tick();
        chk("exc_pc",       128'(out_pc_w[1]),  128'(32'h00400044));
        chk("exc_ex",       128'(out_ex_w[1]),  128'(1));
        chk("exc_excode",   128'(out_exc_w[1]), 128'(5'h04));
        chk("exc_badvaddr", 128'(out_bad_w[1]), 128'(32'h00400001));
        tick();
        chk("exc_next_pc",  128'(out_pc_w[1]),  128'(32'h00400048));
        chk("exc_next_ex",  128'(out_ex_w[1]),  128'(0));
        chk("exc_next_bad", 128'(out_bad_w[1]), 128'(0));
        tick();
        chk("exc_drained",  128'(empty_w[1]),   128'(1));

        // randomized traffic with phases biased toward filling and draining
        for (int c = 0; c < 1000; c++) begin
            rdy_pct = ((c / 100) % 3 == 0) ? 20 : ((c / 100) % 3 == 1) ? 85 : 50;
            drive($urandom_range(99) < 1, $urandom_range(99) < 3,
                  $urandom_range(99) < 70, $urandom_range(99) < rdy_pct,
                  $urandom, $urandom, $urandom_range(99) < 10,
                  5'($urandom), $urandom);
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
